// File: rtl/sipo_shl_pkg.sv
// Shared definitions for the sipo_shl_deser deserializer.
//   buf_state_t  : output-buffer FSM states
//   cnt_width()  : width of the bit counter for a given word width
//   PARITY_BITS  : trailing parity bits per frame (1 when SIPO_SHL_PARITY_EN)
//   frame_len()  : serial bits per frame for a given word width
// Optional feature macro: SIPO_SHL_PARITY_EN
package sipo_shl_pkg;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } buf_state_t;

    // Sized to hold WIDTH itself so the parity build can count 0..WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

`ifdef SIPO_SHL_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int frame_len(input int width);
        return width + PARITY_BITS;
    endfunction

endpackage

// File: rtl/sipo_shl_deser_if.sv
// Serial-input / parallel-output bus of the deserializer.
//   din, din_en  : serial bit and its qualifier (master -> slave)
//   word_ready   : consumer accepts word_out (master -> slave)
//   word_out     : assembled word, first bit in MSB (slave -> master)
//   word_valid   : word_out holds an unconsumed word (slave -> master)
//   bit_cnt      : bits collected into the current frame (slave -> master)
//   overflow     : sticky, a completed word was dropped (slave -> master)
//   parity_err   : parity check of the held word (only with SIPO_SHL_PARITY_EN)
// Optional feature macro: SIPO_SHL_PARITY_EN
interface sipo_shl_deser_if
    import sipo_shl_pkg::*;
#(
    parameter int WIDTH = 4
);
    localparam int CNT_W = cnt_width(WIDTH);

    logic             din;
    logic             din_en;
    logic             word_ready;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic [CNT_W-1:0] bit_cnt;
    logic             overflow;

`ifdef SIPO_SHL_PARITY_EN
    logic             parity_err;

    modport master (output din, din_en, word_ready,
                    input  word_out, word_valid, bit_cnt, overflow, parity_err);
    modport slave  (input  din, din_en, word_ready,
                    output word_out, word_valid, bit_cnt, overflow, parity_err);
`else
    modport master (output din, din_en, word_ready,
                    input  word_out, word_valid, bit_cnt, overflow);
    modport slave  (input  din, din_en, word_ready,
                    output word_out, word_valid, bit_cnt, overflow);
`endif

endinterface

// File: rtl/sipo_bit_counter.sv
// Enable-driven frame bit counter.
//   clk, rst : clock, synchronous active-high reset
//   en       : count this cycle
//   cnt      : current count, 0..TERMINAL
//   tc       : terminal-count pulse, high when en=1 and cnt==TERMINAL
// The count wraps to 0 on the cycle tc is asserted.
module sipo_bit_counter #(
    parameter int CNT_W    = 3,
    parameter int TERMINAL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TERMINAL);

    assign tc = en && (cnt == TERM);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sipo_shl_deser.sv
// Serial-in parallel-out deserializer, MSB first, with a one-entry output
// buffer behind a valid/ready handshake.
//   clk, rst : clock, synchronous active-high reset (priority over all inputs)
//   bus      : sipo_shl_deser_if.slave (din/din_en in, word_* / bit_cnt /
//              overflow [/ parity_err] out)
// Optional feature macro: SIPO_SHL_PARITY_EN -- each frame carries a trailing
// even-parity bit which is checked into parity_err instead of word_out.
module sipo_shl_deser
    import sipo_shl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    sipo_shl_deser_if.slave   bus
);
    localparam int CNT_W = cnt_width(WIDTH);
    localparam int FRAME = frame_len(WIDTH);

    buf_state_t       state_q, state_d;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] new_word;
    logic             overflow_q;
    logic             complete;
    logic             shift_en;
    logic             load;
    logic             set_ovf;

    sipo_bit_counter #(
        .CNT_W    (CNT_W),
        .TERMINAL (FRAME - 1)
    ) u_bit_counter (
        .clk (clk),
        .rst (rst),
        .en  (bus.din_en),
        .cnt (bus.bit_cnt),
        .tc  (complete)
    );

`ifdef SIPO_SHL_PARITY_EN
    logic perr_q;
    logic new_perr;

    // The parity bit never enters the shift register, so on completion sr
    // already holds the full data word.
    assign shift_en = bus.din_en && !complete;
    assign new_word = sr;
    assign new_perr = ^{sr, bus.din};
    assign bus.parity_err = perr_q;
`else
    assign shift_en = bus.din_en;
    assign new_word = {sr[WIDTH-2:0], bus.din};
`endif

    // Output buffer FSM: next state and load/drop decisions.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        set_ovf = 1'b0;
        unique case (state_q)
            S_EMPTY: begin
                if (complete) begin
                    load    = 1'b1;
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (bus.word_ready) begin
                    // A completion in the same cycle refills without a bubble.
                    load    = complete;
                    state_d = complete ? S_FULL : S_EMPTY;
                end else if (complete) begin
                    set_ovf = 1'b1;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // NOTE: every register here, data path included, is reset so outputs are
    // defined from the first cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            sr         <= '0;
            word_q     <= '0;
            overflow_q <= 1'b0;
`ifdef SIPO_SHL_PARITY_EN
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (shift_en) begin
                sr <= {sr[WIDTH-2:0], bus.din};
            end
            if (load) begin
                word_q <= new_word;
`ifdef SIPO_SHL_PARITY_EN
                perr_q <= new_perr;
`endif
            end
            if (set_ovf) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.word_out   = word_q;
    assign bus.word_valid = (state_q == S_FULL);
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_sipo_shl_deser.sv
// Self-checking bench for sipo_shl_deser (WIDTH=4).
// Default build: vector table covering reset, gapped input, back-to-back
// refill, overflow and reset mid-word, then a randomized scoreboard stream.
// With SIPO_SHL_PARITY_EN: hand-written parity frames plus the scoreboard
// stream with a correct parity bit appended to every frame.
module tb_sipo_shl_deser;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sipo_shl_deser_if #(.WIDTH(WIDTH)) bus ();

    sipo_shl_deser #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       rst;
        logic       din;
        logic       en;
        logic       rdy;
        logic [3:0] word;
        logic       valid;
        logic [2:0] cnt;
        logic       ovf;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic r, input logic d, input logic e, input logic y);
        rst        = r;
        bus.din    = d;
        bus.din_en = e;
        bus.word_ready = y;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic r, input logic d, input logic e, input logic y,
                                input logic [3:0] w, input logic v, input logic [2:0] c,
                                input logic o);
        vec_t t;
        t.rst = r; t.din = d; t.en = e; t.rdy = y;
        t.word = w; t.valid = v; t.cnt = c; t.ovf = o;
        vecs.push_back(t);
    endfunction

    // Four consecutive bits of w, MSB first, word_ready=0 except on the last bit.
    function automatic void add_word(input logic [3:0] w, input logic [3:0] hold_w,
                                     input logic hold_v, input logic hold_o,
                                     input logic rdy_last, input logic [3:0] end_w,
                                     input logic end_v, input logic end_o);
        for (int i = 0; i < 3; i++)
            add(1'b0, w[3-i], 1'b1, 1'b0, hold_w, hold_v, 3'(i + 1), hold_o);
        add(1'b0, w[0], 1'b1, rdy_last, end_w, end_v, 3'd0, end_o);
    endfunction

    // Every cycle with word_valid=1 under word_ready=1 is a distinct word.
    task automatic monitor();
        if (bus.word_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got word %0h expected none", bus.word_out);
            end else begin
                check("sb_word", 32'(bus.word_out), 32'(exp_q.pop_front()));
`ifdef SIPO_SHL_PARITY_EN
                check("sb_parity_err", 32'(bus.parity_err), 32'd0);
`endif
            end
        end
    endtask

    task automatic send_word(input logic [3:0] w);
        logic [4:0] frame;
        int nbits;
`ifdef SIPO_SHL_PARITY_EN
        frame = {w, ^w};
        nbits = 5;
`else
        frame = {1'b0, w};
        nbits = 4;
`endif
        for (int i = nbits - 1; i >= 0; i--) begin
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
                monitor();
            end
            step(1'b0, frame[i], 1'b1, 1'b1);
            if (i == 0) exp_q.push_back(w);
            monitor();
        end
    endtask

    initial begin
        bus.din        = 1'b0;
        bus.din_en     = 1'b0;
        bus.word_ready = 1'b0;

`ifdef SIPO_SHL_PARITY_EN
        // Data 1101 with parity 1 (even) -> no error.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("par_reset_err", 32'(bus.parity_err), 32'd0);
        check("par_reset_valid", 32'(bus.word_valid), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("par_cnt_before_parity", 32'(bus.bit_cnt), 32'd4);
        check("par_valid_before_parity", 32'(bus.word_valid), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("par_ok_word", 32'(bus.word_out), 32'hD);
        check("par_ok_valid", 32'(bus.word_valid), 32'd1);
        check("par_ok_err", 32'(bus.parity_err), 32'd0);
        check("par_ok_cnt", 32'(bus.bit_cnt), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        // Same data, parity 0 -> error flagged.
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("par_bad_word", 32'(bus.word_out), 32'hD);
        check("par_bad_err", 32'(bus.parity_err), 32'd1);
        check("par_bad_ovf", 32'(bus.overflow), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("par_consumed", 32'(bus.word_valid), 32'd0);
`else
        // Reset, then a partial word interrupted by a 2-cycle reset with din active.
        add(1, 0, 0, 0, 4'h0, 0, 3'd0, 0);
        add(0, 1, 1, 0, 4'h0, 0, 3'd1, 0);
        add(0, 0, 1, 0, 4'h0, 0, 3'd2, 0);
        add(1, 1, 1, 0, 4'h0, 0, 3'd0, 0);
        add(1, 0, 1, 0, 4'h0, 0, 3'd0, 0);
        // 1011 with word_ready=0: valid the cycle after the 4th bit.
        add_word(4'hB, 4'h0, 0, 0, 0, 4'hB, 1, 0);
        add(0, 0, 0, 1, 4'hB, 0, 3'd0, 0);          // consume
        add(0, 0, 0, 1, 4'hB, 0, 3'd0, 0);          // ready while empty ignored
        // Gapped 0110: three idle cycles (din toggling, en=0) between bits.
        begin
            logic [3:0] g;
            g = 4'b0110;
            for (int i = 0; i < 4; i++) begin
                add(0, g[3-i], 1, 0, (i == 3) ? 4'h6 : 4'hB, (i == 3), 3'((i + 1) % 4), 0);
                if (i < 3)
                    for (int k = 0; k < 3; k++)
                        add(0, ~g[3-i], 0, 0, 4'hB, 0, 3'(i + 1), 0);
            end
        end
        add(0, 0, 0, 1, 4'h6, 0, 3'd0, 0);          // consume
        // Back-to-back: A held, 5 completes with word_ready=1 -> refill, no bubble.
        add_word(4'hA, 4'h6, 0, 0, 0, 4'hA, 1, 0);
        add_word(4'h5, 4'hA, 1, 0, 1, 4'h5, 1, 0);
        add(0, 0, 0, 1, 4'h5, 0, 3'd0, 0);
        // Overflow: 3 held, C dropped.
        add_word(4'h3, 4'h5, 0, 0, 0, 4'h3, 1, 0);
        add_word(4'hC, 4'h3, 1, 0, 0, 4'h3, 1, 1);
        add(0, 0, 0, 1, 4'h3, 0, 3'd0, 1);
        add(0, 1, 0, 0, 4'h3, 0, 3'd0, 1);
        // Reset mid-word, then 9 with no stale bits.
        add(0, 1, 1, 0, 4'h3, 0, 3'd1, 1);
        add(0, 1, 1, 0, 4'h3, 0, 3'd2, 1);
        add(1, 0, 0, 0, 4'h0, 0, 3'd0, 0);
        add_word(4'h9, 4'h0, 0, 0, 0, 4'h9, 1, 0);
        add(1, 0, 0, 1, 4'h0, 0, 3'd0, 0);          // reset while full

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].din, vecs[i].en, vecs[i].rdy);
            check($sformatf("v%0d_word", i), 32'(bus.word_out), 32'(vecs[i].word));
            check($sformatf("v%0d_valid", i), 32'(bus.word_valid), 32'(vecs[i].valid));
            check($sformatf("v%0d_cnt", i), 32'(bus.bit_cnt), 32'(vecs[i].cnt));
            check($sformatf("v%0d_ovf", i), 32'(bus.overflow), 32'(vecs[i].ovf));
        end
`endif

        // Randomized stream with word_ready held high, gaps in din_en.
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 24; n++)
            send_word(4'($urandom_range(0, 15)));
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            monitor();
        end
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("sb_no_overflow", 32'(bus.overflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
